// File: rtl/mux_1hot_pkg.sv
// Shared types and select-encoding helpers for mux_1hot.
// Sel vectors are zero-extended to SEL_MAX bits so one function serves any INPUTS <= SEL_MAX.
package mux_1hot_pkg;

   localparam int SEL_MAX = 64;
   localparam int IDX_W   = $clog2(SEL_MAX);

   typedef logic [SEL_MAX-1:0] sel_vec_t;
   typedef logic [IDX_W-1:0]   sel_idx_t;

   function automatic logic is_onehot(sel_vec_t v);
      return (v != '0) && ((v & (v - sel_vec_t'(1))) == '0);
   endfunction

   // Returns the lowest set bit, which is the only one for a legal select.
   function automatic sel_idx_t onehot_to_idx(sel_vec_t v);
      sel_idx_t idx;
      idx = '0;
      for (int i = SEL_MAX - 1; i >= 0; i--)
         if (v[i]) idx = sel_idx_t'(i);
      return idx;
   endfunction

endpackage

// File: rtl/mux_1hot_if.sv
// Bus bundle for mux_1hot: flat data inputs, one-hot select, selected output and select status.
interface mux_1hot_if #(
   parameter int WIDTH  = 3,
   parameter int INPUTS = 3
);
   logic [INPUTS*WIDTH-1:0] in;
   logic [INPUTS-1:0]       sel;
   logic [WIDTH-1:0]        out;
   logic                    sel_ok;
   logic                    sel_err;

   modport master (output in, sel, input out, sel_ok, sel_err);
   modport slave  (input in, sel, output out, sel_ok, sel_err);
endinterface

// File: rtl/mux_1hot_chk.sv
// Select-encoding checker: sticky flag set by any non-one-hot sel sampled outside reset.
// Instantiated by mux_1hot only when MUX_1HOT_CHECK_EN is defined.
module mux_1hot_chk
   import mux_1hot_pkg::*;
#(
   parameter int INPUTS = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [INPUTS-1:0] sel,
   output logic              sel_err
);

   logic ok;
   assign ok = is_onehot(sel_vec_t'(sel));

   // Reset wins over a bad sel on the same edge.
   always_ff @(posedge clk) begin
      if (reset)
         sel_err <= 1'b0;
      else if (!ok)
         sel_err <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset && !ok)
         $error("mux_1hot: non-one-hot sel=%b (lowest set idx %0d)",
                sel, onehot_to_idx(sel_vec_t'(sel)));
   end

endmodule

// File: rtl/mux_1hot.sv
// One-hot-select multiplexer: combinational AND-OR datapath plus select qualification.
// Optional checker enabled by MUX_1HOT_CHECK_EN; otherwise sel_err is tied low.
module mux_1hot
   import mux_1hot_pkg::*;
#(
   parameter int WIDTH  = 3,
   parameter int INPUTS = 3
) (
   input logic      clk,
   input logic      reset,
   mux_1hot_if.slave bus
);

   logic [INPUTS-1:0][WIDTH-1:0] masked;
   logic [WIDTH-1:0]             acc;

   for (genvar k = 0; k < INPUTS; k++) begin : g_mask
      assign masked[k] = bus.in[k*WIDTH +: WIDTH] & {WIDTH{bus.sel[k]}};
   end

   // Plain OR of all masked slices: multi-hot selects merge, no priority.
   always_comb begin
      acc = '0;
      for (int k = 0; k < INPUTS; k++)
         acc = acc | masked[k];
   end

   assign bus.out    = acc;
   assign bus.sel_ok = is_onehot(sel_vec_t'(bus.sel));

`ifdef MUX_1HOT_CHECK_EN
   mux_1hot_chk #(.INPUTS(INPUTS)) u_chk (
      .clk     (clk),
      .reset   (reset),
      .sel     (bus.sel),
      .sel_err (bus.sel_err)
   );
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ reset;
   assign bus.sel_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mux_1hot.sv
// Directed bench for mux_1hot (WIDTH=3, INPUTS=3); sel_err expectations follow MUX_1HOT_CHECK_EN.
module tb_mux_1hot;

`ifdef MUX_1HOT_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   mux_1hot_if #(.WIDTH(3), .INPUTS(3)) bus ();

   mux_1hot #(.WIDTH(3), .INPUTS(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] walk_sel [3] = '{3'b001, 3'b010, 3'b100};
   logic [2:0] walk_out [3] = '{3'b001, 3'b010, 3'b011};

   logic [2:0] multi_sel [4] = '{3'b101, 3'b110, 3'b111, 3'b010};
   logic [2:0] multi_out [4] = '{3'b101, 3'b110, 3'b111, 3'b110};

   initial begin
      reset   = 1'b1;
      bus.in  = 9'b011_010_001;
      bus.sel = 3'b001;
      step();
      reset = 1'b0;
      check("rst_err", 32'(bus.sel_err), 32'(0));
      check("rst_out", 32'(bus.out), 32'(3'b001));
      check("rst_ok",  32'(bus.sel_ok), 32'(1));

      for (int i = 0; i < 3; i++) begin
         bus.sel = walk_sel[i];
         #1;
         check($sformatf("walk_out%0d", i), 32'(bus.out), 32'(walk_out[i]));
         check($sformatf("walk_ok%0d", i),  32'(bus.sel_ok), 32'(1));
         step();
         check($sformatf("walk_err%0d", i), 32'(bus.sel_err), 32'(0));
      end

      bus.sel = 3'b000;
      #1;
      check("zero_out", 32'(bus.out), 32'(0));
      check("zero_ok",  32'(bus.sel_ok), 32'(0));
      step();
      check("zero_err", 32'(bus.sel_err), 32'(CHK));

      reset   = 1'b1;
      bus.sel = 3'b001;
      step();
      reset = 1'b0;
      check("clr_err", 32'(bus.sel_err), 32'(0));

      bus.sel = 3'b011;
      #1;
      check("dbl_out", 32'(bus.out), 32'(3'b011));
      check("dbl_ok",  32'(bus.sel_ok), 32'(0));
      step();
      check("dbl_err", 32'(bus.sel_err), 32'(CHK));
      bus.sel = 3'b001;
      step();
      check("sticky_err", 32'(bus.sel_err), 32'(CHK));
      check("sticky_ok",  32'(bus.sel_ok), 32'(1));
      step();
      check("sticky_err2", 32'(bus.sel_err), 32'(CHK));

      reset   = 1'b1;
      bus.sel = 3'b110;
      step();
      check("rst_prio_err", 32'(bus.sel_err), 32'(0));
      check("rst_prio_out", 32'(bus.out), 32'(3'b011));
      reset = 1'b0;
      step();
      check("post_rst_err", 32'(bus.sel_err), 32'(CHK));

      bus.in = 9'b100_110_101;
      for (int i = 0; i < 4; i++) begin
         bus.sel = multi_sel[i];
         #1;
         check($sformatf("multi_out%0d", i), 32'(bus.out), 32'(multi_out[i]));
      end
      bus.sel = 3'b100;
      #1;
      check("in2_ok", 32'(bus.sel_ok), 32'(1));
      check("in2_out", 32'(bus.out), 32'(3'b100));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
